// File: rtl/dmem_responder_if.sv
// Core-to-DMEM bus: load/store strobes, byte address, store data and size code out; load data, busy and error back.
interface dmem_responder_if;
  logic        RD;
  logic        WR;
  logic [31:0] A_DMEM;
  logic [31:0] D_out;
  logic [2:0]  byte_mark;
  logic        DMEM_rst;
  logic [31:0] D_in;
  logic        busy;
  logic        misalign_err;

  modport master (
    output RD, WR, A_DMEM, D_out, byte_mark, DMEM_rst,
    input  D_in, busy, misalign_err
  );

  modport slave (
    input  RD, WR, A_DMEM, D_out, byte_mark, DMEM_rst,
    output D_in, busy, misalign_err
  );
endinterface

// File: rtl/dmem_responder.sv
// DMEM slave: byte-masked stores (same edge), loads 1 cycle later with sign/zero extension, DEPTH-cycle clear sweep.
// DMEM_ALIGN_CHECK_EN enables rejection of misaligned/illegal accesses; otherwise addresses are force-aligned.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  typedef enum logic [0:0] {IDLE, CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]       idx;
  logic                    is_byte, is_half, is_signed, ok;
  logic [1:0]              off;
  logic [3:0]              be;
  logic [31:0]             wdat, rword, shifted, ext;
  logic                    we;
  logic [3:0]              wbe;
  logic [ADDR_W-1:0]       widx;
  logic [31:0]             wval;
  logic                    unused_addr;

  assign idx         = bus.A_DMEM[ADDR_W+1:2];
  assign unused_addr = ^bus.A_DMEM[31:ADDR_W+2];

  always_comb begin
    is_signed = ~bus.byte_mark[2];
`ifdef DMEM_ALIGN_CHECK_EN
    begin
      logic legal;
      legal   = (bus.byte_mark == 3'b000) || (bus.byte_mark == 3'b001) ||
                (bus.byte_mark == 3'b010) || (bus.byte_mark == 3'b100) ||
                (bus.byte_mark == 3'b101);
      is_byte = legal && (bus.byte_mark[1:0] == 2'b00);
      is_half = legal && (bus.byte_mark[1:0] == 2'b01);
      off     = bus.A_DMEM[1:0];
      ok      = legal && (is_byte || (is_half && !bus.A_DMEM[0]) ||
                          (!is_byte && !is_half && (bus.A_DMEM[1:0] == 2'b00)));
    end
`else
    // Codes 011/110/111 fall through to word accesses
    is_byte = (bus.byte_mark[1:0] == 2'b00);
    is_half = (bus.byte_mark[1:0] == 2'b01);
    off     = is_byte ? bus.A_DMEM[1:0] : (is_half ? {bus.A_DMEM[1], 1'b0} : 2'b00);
    ok      = 1'b1;
`endif
  end

  always_comb begin
    be      = is_byte ? (4'b0001 << off) : (is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111);
    wdat    = is_byte ? {4{bus.D_out[7:0]}} : (is_half ? {2{bus.D_out[15:0]}} : bus.D_out);
    rword   = mem[idx];
    shifted = rword >> {off, 3'b000};
    if (is_byte)      ext = {{24{is_signed & shifted[7]}}, shifted[7:0]};
    else if (is_half) ext = {{16{is_signed & shifted[15]}}, shifted[15:0]};
    else              ext = rword;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    err_d   = 1'b0;
    we      = 1'b0;
    wbe     = be;
    widx    = idx;
    wval    = wdat;
    case (state_q)
      IDLE: begin
        if (bus.DMEM_rst) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        if (bus.WR) begin
          // A simultaneous load is dropped in favour of the store
          we    = ok;
          err_d = !ok;
          if (bus.RD) din_d = '0;
        end else if (bus.RD) begin
          din_d = ok ? ext : '0;
          err_d = !ok;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        wbe   = 4'b1111;
        widx  = cnt_q;
        wval  = '0;
        din_d = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; reset only suppresses the write in flight
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[widx][8*b +: 8] <= wval[8*b +: 8];
      end
    end
  end

  assign bus.D_in = din_q;
  assign bus.busy = (state_q == CLEAR);
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.misalign_err = err_q;
`else
  logic unused_err;
  assign unused_err       = err_q;
  assign bus.misalign_err = 1'b0;
`endif

endmodule
